// File: rtl/jpeg_idct_transpose_rd_if.sv
// Output sample stream of the IDCT buffer readout: valid/accept handshake
// carrying the sample data, its block index k and a last-of-block flag.
interface jpeg_idct_transpose_rd_if;
    logic        outport_valid_o;
    logic [15:0] outport_data_o;
    logic [5:0]  outport_idx_o;
    logic        outport_last_o;
    logic        outport_accept_i;

    modport master (
        output outport_valid_o,
        output outport_data_o,
        output outport_idx_o,
        output outport_last_o,
        input  outport_accept_i
    );

    modport slave (
        input  outport_valid_o,
        input  outport_data_o,
        input  outport_idx_o,
        input  outport_last_o,
        output outport_accept_i
    );
endinterface

// File: rtl/jpeg_idct_transpose_rd.sv
// Reads one 8x8 block of 16-bit samples from the IDCT buffer and streams it out
// through a 2-entry FIFO. Define JPEG_IDCT_TRANSPOSE_EN for column-major read order.
module jpeg_idct_transpose_rd (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic [5:0]                ram_addr_o,
    input  logic [15:0]               ram_data_i,
    output logic                      done_o,
    jpeg_idct_transpose_rd_if.master  outport
);

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned IDX_W      = 6;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(63);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  idx;
        logic              last;
    } sample_t;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] ram_addr_q, ram_addr_d;
    logic             inflight_q, inflight_d;
    logic [IDX_W-1:0] inflight_idx_q, inflight_idx_d;
    logic [1:0]       occ_q, occ_d;
    sample_t          head_q, head_d;
    sample_t          tail_q, tail_d;
    logic             head_vld_q, head_vld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             pop;
    logic             push;
    logic             issue;
    sample_t          push_s;

    // Buffer address for sample k in the selected read order.
    function automatic logic [IDX_W-1:0] addr_of(input logic [IDX_W-1:0] k);
`ifdef JPEG_IDCT_TRANSPOSE_EN
        return {k[2:0], k[5:3]};
`else
        return k;
`endif
    endfunction

    // Next-state, read issue and FIFO update.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ram_addr_d     = ram_addr_q;
        inflight_d     = 1'b0;
        inflight_idx_d = inflight_idx_q;
        occ_d          = occ_q;
        head_d         = head_q;
        tail_d         = tail_q;
        done_d         = 1'b0;
        issue          = 1'b0;
        pop            = (occ_q != 2'd0) && outport.outport_accept_i;
        push           = inflight_q;
        push_s.data    = ram_data_i;
        push_s.idx     = inflight_idx_q;
        push_s.last    = (inflight_idx_q == LAST_IDX);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = READ;
                    cnt_d   = '0;
                end
            end
            READ: begin
                ram_addr_d = addr_of(cnt_q);
                // A pop on this edge frees a slot in time for the read issued now.
                issue = (3'(occ_q) + 3'(inflight_q) - 3'(pop)) < 3'(FIFO_DEPTH);
                if (issue) begin
                    inflight_d     = 1'b1;
                    inflight_idx_d = cnt_q;
                    cnt_d          = cnt_q + IDX_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && head_q.last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Shift FIFO: head entry drives the outputs directly.
        occ_d = occ_q + 2'(push) - 2'(pop);
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = push_s;
                else               tail_d = push_s;
            end
            2'b01: head_d = tail_q;
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = push_s;
                end else begin
                    head_d = tail_q;
                    tail_d = push_s;
                end
            end
            default: ;
        endcase

        head_vld_d = (occ_d != 2'd0);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            ram_addr_q     <= '0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= '0;
            occ_q          <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            head_vld_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ram_addr_q     <= ram_addr_d;
            inflight_q     <= inflight_d;
            inflight_idx_q <= inflight_idx_d;
            occ_q          <= occ_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            head_vld_q     <= head_vld_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign busy_o                  = busy_q;
    assign done_o                  = done_q;
    assign ram_addr_o              = ram_addr_q;
    assign outport.outport_valid_o = head_vld_q;
    assign outport.outport_data_o  = head_q.data;
    assign outport.outport_idx_o   = head_q.idx;
    assign outport.outport_last_o  = head_q.last;

endmodule

// File: tb/tb_jpeg_idct_transpose_rd.sv
// Bench for jpeg_idct_transpose_rd: random buffer contents and random accept
// checked against an index/address model of the block readout.
module tb_jpeg_idct_transpose_rd;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        busy;
    logic        done;
    logic [5:0]  ram_addr;
    logic [15:0] ram_data;
    logic [15:0] mem [64];

    int vec_cnt = 0;
    int err_cnt = 0;

    jpeg_idct_transpose_rd_if ifc ();

    jpeg_idct_transpose_rd u_dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .start_i    (start),
        .busy_o     (busy),
        .ram_addr_o (ram_addr),
        .ram_data_i (ram_data),
        .done_o     (done),
        .outport    (ifc)
    );

    // Buffer read data follows the currently presented address.
    assign ram_data = mem[ram_addr];

    always #5 clk = ~clk;

    // Buffer address holding sample k.
    function automatic int ref_addr(input int k);
`ifdef JPEG_IDCT_TRANSPOSE_EN
        return (k % 8) * 8 + k / 8;
`else
        return k;
`endif
    endfunction

    task automatic fill_mem(input bit identity);
        for (int i = 0; i < 64; i++) mem[i] = identity ? 16'(i) : 16'($urandom);
    endtask

    // Drives one readout and checks every transfer against the model.
    task automatic run_block(input bit do_start, input int pct, input int restart_at,
                             input int abort_at, input bit check_lat,
                             output int n_xfer, output int done_edge, output int done_cnt);
        int          cyc = 0;
        int          exp_k = 0;
        int          post = 0;
        bit          restarted = 1'b0;
        bit          prev_stall = 1'b0;
        logic [15:0] pd = '0;
        logic [5:0]  pi = '0;
        logic        pl = 1'b0;
        logic [15:0] exp_d;
        n_xfer    = 0;
        done_edge = -1;
        done_cnt  = 0;
        if (do_start) start = 1'b1;
        while (1) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (restart_at >= 0 && !restarted && n_xfer == restart_at) begin
                start     = 1'b1;
                restarted = 1'b1;
            end
            if (check_lat && cyc == 2) begin
                vec_cnt++;
                if (ifc.outport_valid_o !== 1'b0 || ram_addr !== 6'(ref_addr(0))) begin
                    err_cnt++;
                    $display("FAIL latency_k0: valid=%b addr=%0d, required valid=0 addr=%0d",
                             ifc.outport_valid_o, ram_addr, ref_addr(0));
                end
            end
            if (check_lat && cyc == 3) begin
                vec_cnt++;
                if (ifc.outport_valid_o !== 1'b1 || ram_addr !== 6'(ref_addr(1))) begin
                    err_cnt++;
                    $display("FAIL latency_k1: valid=%b addr=%0d, required valid=1 addr=%0d",
                             ifc.outport_valid_o, ram_addr, ref_addr(1));
                end
            end
            if (prev_stall) begin
                vec_cnt++;
                if (ifc.outport_valid_o !== 1'b1 || ifc.outport_data_o !== pd ||
                    ifc.outport_idx_o !== pi || ifc.outport_last_o !== pl) begin
                    err_cnt++;
                    $display("FAIL stall_stable: v=%b d=%h i=%0d l=%b, required v=1 d=%h i=%0d l=%b",
                             ifc.outport_valid_o, ifc.outport_data_o, ifc.outport_idx_o,
                             ifc.outport_last_o, pd, pi, pl);
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cnt == 1) done_edge = cyc - 1;
                vec_cnt++;
                if (busy !== 1'b0 || ifc.outport_valid_o !== 1'b0 || n_xfer != 64) begin
                    err_cnt++;
                    $display("FAIL done_cycle: busy=%b valid=%b xfers=%0d, required 0 0 64",
                             busy, ifc.outport_valid_o, n_xfer);
                end
            end
            if (done_cnt > 0) post++;
            if (abort_at >= 0 && n_xfer == abort_at) break;
            ifc.outport_accept_i = ($urandom_range(99) < pct);
            if (ifc.outport_valid_o === 1'b1 && ifc.outport_accept_i) begin
                vec_cnt++;
                if (exp_k > 63) begin
                    err_cnt++;
                    $display("FAIL extra_xfer: idx=%0d after 64 transfers, required none",
                             ifc.outport_idx_o);
                end else begin
                    exp_d = mem[ref_addr(exp_k)];
                    if (ifc.outport_idx_o !== 6'(exp_k) || ifc.outport_data_o !== exp_d ||
                        ifc.outport_last_o !== (exp_k == 63)) begin
                        err_cnt++;
                        $display("FAIL xfer_k%0d: d=%h i=%0d l=%b, required d=%h i=%0d l=%b",
                                 exp_k, ifc.outport_data_o, ifc.outport_idx_o,
                                 ifc.outport_last_o, exp_d, exp_k, (exp_k == 63));
                    end
                end
                n_xfer++;
                exp_k++;
            end
            prev_stall = (ifc.outport_valid_o === 1'b1) && !ifc.outport_accept_i;
            pd = ifc.outport_data_o;
            pi = ifc.outport_idx_o;
            pl = ifc.outport_last_o;
            if (post >= 5) break;
            if (cyc > 3000) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL timeout: %0d transfers, done count %0d, required 64 and 1",
                         n_xfer, done_cnt);
                break;
            end
        end
    endtask

    task automatic check_block(input string name, input int n_xfer, input int done_cnt);
        vec_cnt++;
        if (n_xfer != 64 || done_cnt != 1) begin
            err_cnt++;
            $display("FAIL %s_count: xfers=%0d dones=%0d, required 64 and 1", name, n_xfer, done_cnt);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        start = 1'b0;
        ifc.outport_accept_i = 1'b0;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if ({busy, done, ifc.outport_valid_o, ifc.outport_last_o, ifc.outport_data_o,
             ifc.outport_idx_o, ram_addr} !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs: busy=%b done=%b v=%b l=%b d=%h i=%0d a=%0d, required all 0",
                     busy, done, ifc.outport_valid_o, ifc.outport_last_o, ifc.outport_data_o,
                     ifc.outport_idx_o, ram_addr);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_rate(input bit identity);
        int n, de, dc;
        fill_mem(identity);
        run_block(1'b1, 100, -1, -1, 1'b1, n, de, dc);
        check_block("full_rate", n, dc);
        vec_cnt++;
        if (de != 66) begin
            err_cnt++;
            $display("FAIL done_edge: done after edge %0d, required 66", de);
        end
    endtask

    task automatic test_random_accept();
        int n, de, dc;
        fill_mem(1'b0);
        run_block(1'b1, 30, -1, -1, 1'b0, n, de, dc);
        check_block("accept30", n, dc);
    endtask

    task automatic test_restart();
        int n, de, dc;
        fill_mem(1'b0);
        run_block(1'b1, 70, 20, -1, 1'b0, n, de, dc);
        check_block("restart", n, dc);
    endtask

    task automatic test_reset_mid();
        int n, de, dc;
        fill_mem(1'b0);
        run_block(1'b1, 80, -1, 30, 1'b0, n, de, dc);
        rstn = 1'b0;
        #1;
        vec_cnt++;
        if ({busy, done, ifc.outport_valid_o, ifc.outport_last_o, ifc.outport_data_o,
             ifc.outport_idx_o, ram_addr} !== '0) begin
            err_cnt++;
            $display("FAIL midreset_outputs: busy=%b v=%b d=%h i=%0d a=%0d, required all 0",
                     busy, ifc.outport_valid_o, ifc.outport_data_o, ifc.outport_idx_o, ram_addr);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        ifc.outport_accept_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vec_cnt++;
            if (ifc.outport_valid_o !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                err_cnt++;
                $display("FAIL post_reset_idle: v=%b done=%b busy=%b, required 0 0 0",
                         ifc.outport_valid_o, done, busy);
            end
        end
        run_block(1'b1, 60, -1, -1, 1'b0, n, de, dc);
        check_block("after_reset", n, dc);
    endtask

    task automatic test_stall_start();
        int n, de, dc;
        fill_mem(1'b0);
        ifc.outport_accept_i = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        vec_cnt++;
        if (ram_addr !== 6'(ref_addr(2)) || ifc.outport_valid_o !== 1'b1 ||
            ifc.outport_idx_o !== 6'd0 || ifc.outport_data_o !== mem[ref_addr(0)] || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL stall_hold: a=%0d v=%b i=%0d d=%h busy=%b, required a=%0d v=1 i=0 d=%h busy=1",
                     ram_addr, ifc.outport_valid_o, ifc.outport_idx_o, ifc.outport_data_o, busy,
                     ref_addr(2), mem[ref_addr(0)]);
        end
        run_block(1'b0, 100, -1, -1, 1'b0, n, de, dc);
        check_block("stall_resume", n, dc);
    endtask

    initial begin
        fill_mem(1'b1);
        test_reset();
        test_full_rate(1'b1);
        test_full_rate(1'b0);
        test_random_accept();
        test_random_accept();
        test_restart();
        test_reset_mid();
        test_stall_start();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
